// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared op codes, FSM states and op classification helpers for ex_mem_stage
package ex_mem_pkg;

    localparam int MEM_OP_W = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        NOP       = 4'd0,
        WRITE_REG = 4'd1,
        LB        = 4'd2,
        LBU       = 4'd3,
        LH        = 4'd4,
        LHU       = 4'd5,
        LW        = 4'd6,
        LWU       = 4'd7,
        LD        = 4'd8,
        SB        = 4'd9,
        SH        = 4'd10,
        SW        = 4'd11,
        SD        = 4'd12
    } mem_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_e;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return (op >= LB) && (op <= LD);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return (op >= SB) && (op <= SD);
    endfunction

    function automatic logic is_sext(input logic [MEM_OP_W-1:0] op);
        return (op == LB) || (op == LH) || (op == LW);
    endfunction

    // log2 of the access size in bytes: 0 byte, 1 half, 2 word, 3 doubleword
    function automatic logic [1:0] op_size(input logic [MEM_OP_W-1:0] op);
        case (op)
            LB, LBU, SB: return 2'd0;
            LH, LHU, SH: return 2'd1;
            LD, SD:      return 2'd3;
            default:     return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_lane.sv
// rtl/ex_mem_lane.sv - byte-lane steering: enables, store replication, load extraction (option: EX_MEM_MISALIGN_TRAP_EN)
module ex_mem_lane
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8,
    localparam int OFS_W = $clog2(SEL_W)
) (
    input  logic [MEM_OP_W-1:0] op,
    input  logic [OFS_W-1:0]    ofs,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [DATA_W-1:0]   rdata,
    output logic [SEL_W-1:0]    sel,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   ldata
`ifdef EX_MEM_MISALIGN_TRAP_EN
    ,
    output logic                misalign
`endif
);

    logic [1:0]        size;
    logic [OFS_W-1:0]  mask;
    logic [OFS_W-1:0]  aofs;
    logic [DATA_W-1:0] sh;

    // On a 32-bit datapath the doubleword mask truncates to the word mask, so LD/SD act as full-width word accesses
    always_comb begin
        size  = op_size(op);
        mask  = OFS_W'((1 << size) - 1);
        aofs  = ofs & ~mask;
        sh    = rdata >> {aofs, 3'b000};
        sel   = '1;
        wdata = wdata_in;
        ldata = sh;
        case (size)
            2'd0: begin
                sel   = SEL_W'(1) << aofs;
                wdata = {SEL_W{wdata_in[7:0]}};
                ldata = is_sext(op) ? DATA_W'($signed(sh[7:0])) : DATA_W'(sh[7:0]);
            end
            2'd1: begin
                sel   = SEL_W'(2'b11) << aofs;
                wdata = {(SEL_W/2){wdata_in[15:0]}};
                ldata = is_sext(op) ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0]);
            end
            2'd2: begin
                sel   = SEL_W'(4'hF) << aofs;
                wdata = {(SEL_W/4){wdata_in[31:0]}};
                ldata = is_sext(op) ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0]);
            end
            default: begin
                sel   = '1;
                wdata = wdata_in;
                ldata = sh;
            end
        endcase
    end

`ifdef EX_MEM_MISALIGN_TRAP_EN
    assign misalign = |(ofs & mask);
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM stage with req/ack memory port and writeback beat (option: EX_MEM_MISALIGN_TRAP_EN)
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    localparam int SEL_W     = DATA_W / 8,
    localparam int OFS_W     = $clog2(SEL_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [MEM_OP_W-1:0]     ex_memOp,
    input  logic [DATA_W-1:0]       ex_result,
    input  logic [ADDR_W-1:0]       ex_memAddr,
    input  logic [REG_ADDR_W-1:0]   ex_regDest,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-OFS_W-1:0] mem_addr,
    output logic [SEL_W-1:0]        mem_sel,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack,
    output logic                    wb_valid,
`ifdef EX_MEM_MISALIGN_TRAP_EN
    output logic                    wb_excMisalign,
`endif
    output logic                    wb_regWe,
    output logic [REG_ADDR_W-1:0]   wb_regDest,
    output logic [DATA_W-1:0]       wb_data
);

    state_e                state, state_nxt;
    logic                  killed;
    logic [MEM_OP_W-1:0]   op_q;
    logic [OFS_W-1:0]      ofs_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [MEM_OP_W-1:0]   lane_op;
    logic [OFS_W-1:0]      lane_ofs;
    logic [SEL_W-1:0]      lane_sel;
    logic [DATA_W-1:0]     lane_wdata;
    logic [DATA_W-1:0]     lane_ldata;
    logic                  capture;
    logic                  is_mem;
    logic                  trap;
    logic                  go_mem;

    assign ex_ready = (state == S_IDLE);
    assign capture  = ex_ready && ex_valid && !flush;
    assign is_mem   = is_load(ex_memOp) || is_store(ex_memOp);
    assign go_mem   = capture && is_mem && !trap;

    // One lane unit serves both phases: request formatting in S_IDLE, load extraction in S_MEM
    assign lane_op  = (state == S_MEM) ? op_q  : ex_memOp;
    assign lane_ofs = (state == S_MEM) ? ofs_q : ex_memAddr[OFS_W-1:0];

`ifdef EX_MEM_MISALIGN_TRAP_EN
    logic lane_misalign;
    assign trap = capture && is_mem && lane_misalign;
`else
    assign trap = 1'b0;
`endif

    ex_mem_lane #(.DATA_W(DATA_W)) u_lane (
        .op       (lane_op),
        .ofs      (lane_ofs),
        .wdata_in (ex_result),
        .rdata    (mem_rdata),
        .sel      (lane_sel),
        .wdata    (lane_wdata),
        .ldata    (lane_ldata)
`ifdef EX_MEM_MISALIGN_TRAP_EN
        ,
        .misalign (lane_misalign)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go_mem)  state_nxt = S_MEM;
            S_MEM:   if (mem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            killed     <= 1'b0;
            op_q       <= '0;
            ofs_q      <= '0;
            dest_q     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_sel    <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_regWe   <= 1'b0;
            wb_regDest <= '0;
            wb_data    <= '0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
            wb_excMisalign <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (capture && ex_memOp == WRITE_REG) begin
                    wb_valid   <= 1'b1;
                    wb_regWe   <= 1'b1;
                    wb_regDest <= ex_regDest;
                    wb_data    <= ex_result;
`ifdef EX_MEM_MISALIGN_TRAP_EN
                    wb_excMisalign <= 1'b0;
`endif
                end
`ifdef EX_MEM_MISALIGN_TRAP_EN
                if (trap) begin
                    wb_valid       <= 1'b1;
                    wb_regWe       <= 1'b0;
                    wb_regDest     <= ex_regDest;
                    wb_data        <= DATA_W'(ex_memAddr);
                    wb_excMisalign <= 1'b1;
                end
`endif
                if (go_mem) begin
                    killed    <= 1'b0;
                    op_q      <= ex_memOp;
                    ofs_q     <= ex_memAddr[OFS_W-1:0];
                    dest_q    <= ex_regDest;
                    mem_req   <= 1'b1;
                    mem_we    <= is_store(ex_memOp);
                    mem_addr  <= ex_memAddr[ADDR_W-1:OFS_W];
                    mem_sel   <= lane_sel;
                    mem_wdata <= lane_wdata;
                end
            end else begin
                // A killed access still completes its handshake; only the writeback is dropped
                if (flush) begin
                    killed <= 1'b1;
                end
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (!killed && !flush) begin
                        wb_valid   <= 1'b1;
                        wb_regWe   <= !mem_we;
                        wb_regDest <= dest_q;
`ifdef EX_MEM_MISALIGN_TRAP_EN
                        wb_excMisalign <= 1'b0;
`endif
                        if (!mem_we) begin
                            wb_data <= lane_ldata;
                        end
                    end
                end
            end
        end
    end

endmodule
